// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD sync generator: FSM state encoding, default
// panel timing and coordinate widths derived from that timing.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } lcd_state_e;

    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FP_DEF     = 40;
    localparam int H_SYNC_DEF   = 48;
    localparam int H_BP_DEF     = 40;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 13;
    localparam int V_SYNC_DEF   = 3;
    localparam int V_BP_DEF     = 29;

    localparam int X_W = $clog2(H_ACTIVE_DEF);
    localparam int Y_W = $clog2(V_ACTIVE_DEF);

    // Counter width able to hold 0..total-1, never narrower than one bit.
    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/lcd_sync_gen_if.sv
// Bundle between the LCD sync generator (master) and its consumer (slave).
// frame_cnt exists only when LCD_SYNC_FRAME_CNT_EN is defined.
interface lcd_sync_gen_if;
    import lcd_pkg::*;

    logic             en_sync;
    logic             en;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic             frame_start;
    logic             off_lcd;
`ifdef LCD_SYNC_FRAME_CNT_EN
    logic [15:0]      frame_cnt;

    modport master (
        input  en_sync, en,
        output hsync, vsync, de, x, y, frame_start, off_lcd, frame_cnt
    );
    modport slave (
        output en_sync, en,
        input  hsync, vsync, de, x, y, frame_start, off_lcd, frame_cnt
    );
`else
    modport master (
        input  en_sync, en,
        output hsync, vsync, de, x, y, frame_start, off_lcd
    );
    modport slave (
        output en_sync, en,
        input  hsync, vsync, de, x, y, frame_start, off_lcd
    );
`endif

endinterface

// File: rtl/lcd_timing_counter.sv
// Modulo-TOTAL position counter with synchronous clear; used for both the
// pixel (h) and line (v) axes of the LCD timing.
module lcd_timing_counter
    import lcd_pkg::*;
#(
    parameter int TOTAL = 1028,
    parameter int W     = cnt_width(TOTAL)
) (
    input  logic         clk_lcd,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         terminal,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] cnt_reg;

    assign cnt      = cnt_reg;
    assign terminal = (cnt_reg == LAST);
    assign wrap     = en && terminal;

    always_ff @(posedge clk_lcd or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= terminal ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_sync_gen.sv
// LCD timing generator: hsync/vsync/de plus pixel coordinates, with a drain
// phase that finishes the frame before reporting off_lcd. Optional frame
// counter output under LCD_SYNC_FRAME_CNT_EN.
module lcd_sync_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic          clk_lcd,
    input  logic          rst_n,
    lcd_sync_gen_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FP + V_SYNC);

    lcd_state_e     state_reg, state_next;
    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    logic           h_term, h_wrap, v_term, unused_v_wrap;
    logic           cnt_run, sync_act;

    // Counters only advance while timing is live; otherwise they sit at 0, so
    // dropping en_sync or reset never leaves a partial line behind.
    assign cnt_run  = bus.en_sync && (state_reg == ST_RUN || state_reg == ST_DRAIN);
    assign sync_act = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);

    lcd_timing_counter #(.TOTAL(H_TOTAL), .W(HW)) u_h_cnt (
        .clk_lcd  (clk_lcd),
        .rst_n    (rst_n),
        .clr      (!cnt_run),
        .en       (cnt_run),
        .cnt      (h_cnt),
        .terminal (h_term),
        .wrap     (h_wrap)
    );

    lcd_timing_counter #(.TOTAL(V_TOTAL), .W(VW)) u_v_cnt (
        .clk_lcd  (clk_lcd),
        .rst_n    (rst_n),
        .clr      (!cnt_run),
        .en       (h_wrap),
        .cnt      (v_cnt),
        .terminal (v_term),
        .wrap     (unused_v_wrap)
    );

    always_comb begin
        state_next = state_reg;
        if (!bus.en_sync) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  state_next = ST_RUN;
                ST_RUN:   if (!bus.en) state_next = ST_DRAIN;
                ST_DRAIN: begin
                    if (bus.en)                state_next = ST_RUN;
                    else if (h_term && v_term) state_next = ST_DONE;
                end
                ST_DONE:  state_next = ST_DONE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    logic           de_next, hsync_next, vsync_next, fs_next, off_next;
    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_next;
    logic           hsync_reg, vsync_reg, de_reg, fs_reg, off_reg;
    logic [X_W-1:0] x_reg;
    logic [Y_W-1:0] y_reg;

    always_comb begin
        de_next    = (state_reg == ST_RUN) && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        hsync_next = !(sync_act && h_cnt >= HS_BEG_C && h_cnt < HS_END_C);
        vsync_next = !(sync_act && v_cnt >= VS_BEG_C && v_cnt < VS_END_C);
        fs_next    = de_next && (h_cnt == '0) && (v_cnt == '0);
        off_next   = (state_reg == ST_DONE);
        x_next     = de_next ? X_W'(h_cnt) : x_reg;
        y_next     = de_next ? Y_W'(v_cnt) : y_reg;
    end

    always_ff @(posedge clk_lcd or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
            de_reg    <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
            fs_reg    <= 1'b0;
            off_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            hsync_reg <= hsync_next;
            vsync_reg <= vsync_next;
            de_reg    <= de_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            fs_reg    <= fs_next;
            off_reg   <= off_next;
        end
    end

    assign bus.hsync       = hsync_reg;
    assign bus.vsync       = vsync_reg;
    assign bus.de          = de_reg;
    assign bus.x           = x_reg;
    assign bus.y           = y_reg;
    assign bus.frame_start = fs_reg;
    assign bus.off_lcd     = off_reg;

`ifdef LCD_SYNC_FRAME_CNT_EN
    // Counts in step with the frame_start pin, so it reads N during frame N.
    logic [15:0] frame_cnt_reg;

    always_ff @(posedge clk_lcd or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            frame_cnt_reg <= '0;
        end else if (fs_next) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: doc/lcd_sync_gen.md
LCD_SYNC_GEN -- requirements
Module: lcd_sync_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800: active pixels per line.
REQ-002 SHALL have parameters H_FP 40, H_SYNC 48, H_BP 40: horizontal front porch, sync width and back porch, in clocks.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 13, V_SYNC 3, V_BP 29: vertical timing, in lines.
REQ-004 SHALL have port clk_lcd, input, 1: single pixel clock; all state is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port en_sync, input, 1: timing run request from the LCD power controller.
REQ-007 SHALL have port en, input, 1: pixel output enable from the LCD power controller.
REQ-008 SHALL have ports hsync and vsync, output, 1 each: registered sync outputs, active-low.
REQ-009 SHALL have port de, output, 1: registered data enable.
REQ-010 SHALL have ports x (output, 10) and y (output, 9): pixel coordinates aligned with de.
REQ-011 SHALL have port frame_start, output, 1: one-cycle pulse on pixel (0,0).
REQ-012 SHALL have port off_lcd, output, 1: frame drained, so the power controller can remove AVDD.

Function
REQ-013 SHALL use H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-014 SHALL use counters h_cnt from 0 to H_TOTAL-1 and v_cnt from 0 to V_TOTAL-1.
REQ-015 SHALL wrap h_cnt to 0 after H_TOTAL-1 and increment v_cnt at that point; v_cnt SHALL wrap to 0 after V_TOTAL-1.
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: counters held at 0; when en_sync=1, SHALL go to RUN with h_cnt=0 and v_cnt=0.
REQ-018 RUN: counters SHALL count; when en=0, SHALL go to DRAIN and keep counting with no reset of position.
REQ-019 DRAIN: counters SHALL count with de forced 0.
REQ-020 DRAIN: when en=1, SHALL return to RUN; otherwise, at h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, SHALL go to DONE.
REQ-021 DONE: counters held at 0, off_lcd=1; when en_sync=0, SHALL go to IDLE.
REQ-022 When en_sync=0 in any state, SHALL go to IDLE on the next edge; this takes priority over every other transition.
REQ-023 All outputs SHALL be registered, with one cycle of latency from counter/state to pins.
REQ-024 de SHALL be 1 iff state=RUN, h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-025 hsync SHALL be 0 iff h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) and the state is RUN or DRAIN.
REQ-026 vsync SHALL be 0 iff v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) and the state is RUN or DRAIN.
REQ-027 x and y SHALL equal h_cnt and v_cnt while de=1, and SHALL hold their last value otherwise.
REQ-028 frame_start SHALL be 1 for the cycle in which de=1, x=0 and y=0.
REQ-029 off_lcd SHALL be a level, 1 only in DONE, registered.

Reset
REQ-030 When rst_n=0, SHALL asynchronously set state=IDLE, counters 0, hsync=1, vsync=1, de=0, x=0, y=0, frame_start=0, off_lcd=0.
REQ-031 Reset SHALL release synchronously and behave correctly when asserted mid-line or mid-frame; no partial line persists after reset.

Configuration
REQ-032 With macro LCD_SYNC_FRAME_CNT_EN defined, SHALL add output frame_cnt (16), which increments with wrap on each frame_start, resets to 0, and clears in IDLE.
REQ-033 Without LCD_SYNC_FRAME_CNT_EN, SHALL have no frame_cnt port and no counter logic.

Structure
REQ-034 Package lcd_pkg SHALL hold the state enum and the default timing constants; x and y widths SHALL be derived from those constants.
REQ-035 SHALL use one sub-module, lcd_timing_counter, parameterised by total count, with an enable input and wrap/terminal outputs, instantiated twice (h and v).

Verification (bench params: H 8/2/2/2 gives H_TOTAL 14; V 4/1/1/1 gives V_TOTAL 7; 98 clocks per frame)
REQ-036 Hold rst_n=0 -> hsync=1, vsync=1, de=0, x=0, y=0, frame_start=0, off_lcd=0.
REQ-037 Set en_sync=1 and en=1 -> per frame: 32 de cycles, frame_start exactly once, hsync low 2 of every 14 clocks, vsync low for 14 clocks; frame_start repeats every 98 clocks.
REQ-038 Drop en at y=1, x=3 -> de=0 on the next registered cycle and syncs continue; off_lcd=1 one clock after the (13,6) wrap, held until en_sync=0, then IDLE.
REQ-039 Re-raise en during DRAIN at v_cnt=2 -> de resumes at the next active pixel, (0,3); off_lcd stays 0.
REQ-040 Drop en_sync in RUN mid-line -> next cycle de=0 and hsync=vsync=1; a later en_sync=1 starts at (0,0) with frame_start.
REQ-041 Assert rst_n=0 asynchronously mid-line -> outputs reach reset values before the next edge; with LCD_SYNC_FRAME_CNT_EN, frame_cnt=0 and reaches 3 after 3 frames.
